// File: rtl/sw_debounce3_if.sv
// Switch-conditioner bus: raw switch levels in; debounced levels and
// one-cycle edge strobes out.
interface sw_debounce3_if #(
    parameter int N = 3
);
    logic [N-1:0] sw_in;
    logic [N-1:0] sw_out;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         changed;

    // Board/stimulus side: drives the raw switches, observes the conditioned view
    modport master (
        output sw_in,
        input  sw_out,
        input  sw_rise,
        input  sw_fall,
        input  changed
    );

    // Conditioner side
    modport slave (
        input  sw_in,
        output sw_out,
        output sw_rise,
        output sw_fall,
        output changed
    );
endinterface

// File: rtl/sw_debounce3.sv
// sw_debounce3: per-channel two-flop synchroniser followed by a stability
// counter. A channel's clean level only changes once the synchronised input
// has disagreed with it for STABLE_CNT consecutive cycles; any agreeing cycle
// restarts the count. Rise/fall strobes are registered alongside the level
// so they line up with the cycle in which the new level first appears.
module sw_debounce3 #(
    parameter int N          = 3,
    parameter int STABLE_CNT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sw_debounce3_if.slave   bus
);
    localparam int                 CNT_W   = $clog2(STABLE_CNT) + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic [N-1:0]     r_s1;
    logic [N-1:0]     r_s2;
    logic [CNT_W-1:0] r_cnt [N];
    logic [N-1:0]     r_sw_out;
    logic [N-1:0]     r_sw_rise;
    logic [N-1:0]     r_sw_fall;

    logic [CNT_W-1:0] w_cnt_nxt [N];
    logic [N-1:0]     w_out_nxt;
    logic [N-1:0]     w_rise_nxt;
    logic [N-1:0]     w_fall_nxt;

    // Next-state of each channel's debounce counter, level and strobes
    always_comb begin
        w_out_nxt  = r_sw_out;
        w_rise_nxt = {N{1'b0}};
        w_fall_nxt = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i] = {CNT_W{1'b0}};
            if (r_s2[i] == r_sw_out[i]) begin
                // Input agrees with the accepted level: restart qualification
                w_cnt_nxt[i] = {CNT_W{1'b0}};
            end else if (r_cnt[i] == CNT_MAX) begin
                // Disagreement has persisted long enough: accept the new level
                w_cnt_nxt[i]  = {CNT_W{1'b0}};
                w_out_nxt[i]  = r_s2[i];
                w_rise_nxt[i] = r_s2[i];
                w_fall_nxt[i] = ~r_s2[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counters, debounced level and strobes; synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= {N{1'b0}};
            r_s2      <= {N{1'b0}};
            r_sw_out  <= {N{1'b0}};
            r_sw_rise <= {N{1'b0}};
            r_sw_fall <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            r_s1      <= bus.sw_in;
            r_s2      <= r_s1;
            r_sw_out  <= w_out_nxt;
            r_sw_rise <= w_rise_nxt;
            r_sw_fall <= w_fall_nxt;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign bus.sw_out  = r_sw_out;
    assign bus.sw_rise = r_sw_rise;
    assign bus.sw_fall = r_sw_fall;
    // Derived from registered strobes only, so it is glitch-free in practice
    assign bus.changed = |(r_sw_rise | r_sw_fall);

endmodule

// File: tb/tb_sw_debounce3.sv
// Directed bench for sw_debounce3 (N=3, STABLE_CNT=4): a cycle-by-cycle
// vector table for reset/held-high and falling edges, plus hand-written
// sequences for bounce, short glitch, reset mid-count and simultaneous flips.
module tb_sw_debounce3;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sw_debounce3_if #(.N(3)) bus ();

    sw_debounce3 #(.N(3), .STABLE_CNT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] sw_in;
        logic [2:0] exp_out;
        logic [2:0] exp_rise;
        logic [2:0] exp_fall;
        logic       exp_ch;
        string      name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic r, input logic [2:0] i,
                       input logic [2:0] o, input logic [2:0] ri,
                       input logic [2:0] f, input logic c);
        vec_t v;
        v.name = nm; v.rst_n = r; v.sw_in = i;
        v.exp_out = o; v.exp_rise = ri; v.exp_fall = f; v.exp_ch = c;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [2:0] o, input logic [2:0] ri,
                         input logic [2:0] f, input logic c);
        n_checks++;
        if (bus.sw_out !== o || bus.sw_rise !== ri || bus.sw_fall !== f || bus.changed !== c) begin
            n_errors++;
            $display("FAIL %s: got out=%b rise=%b fall=%b ch=%b, expected out=%b rise=%b fall=%b ch=%b",
                     nm, bus.sw_out, bus.sw_rise, bus.sw_fall, bus.changed, o, ri, f, c);
        end
    endtask

    task automatic step(input string nm, input logic [2:0] o, input logic [2:0] ri,
                        input logic [2:0] f, input logic c);
        tick();
        check(nm, o, ri, f, c);
    endtask

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.sw_in = 3'b000;

        // Test 1: reset with inputs held high, then qualification after release
        for (int k = 0; k < 3; k++) add("reset_held", 1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 0; k < 5; k++) add("t1_wait", 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
        add("t1_rise", 1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 1'b1);
        add("t1_after", 1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0);
        // Drop channels 0 and 2 to reach sw_out=010
        for (int k = 0; k < 5; k++) add("to010_wait", 1'b1, 3'b010, 3'b111, 3'b000, 3'b000, 1'b0);
        add("to010_fall", 1'b1, 3'b010, 3'b010, 3'b000, 3'b101, 1'b1);
        add("to010_after", 1'b1, 3'b010, 3'b010, 3'b000, 3'b000, 1'b0);
        // Test 4: falling edge on channel 1
        for (int k = 0; k < 5; k++) add("t4_wait", 1'b1, 3'b000, 3'b010, 3'b000, 3'b000, 1'b0);
        add("t4_fall", 1'b1, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1);
        add("t4_after", 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        foreach (vq[k]) begin
            rst_n     = vq[k].rst_n;
            bus.sw_in = vq[k].sw_in;
            step(vq[k].name, vq[k].exp_out, vq[k].exp_rise, vq[k].exp_fall, vq[k].exp_ch);
        end

        // Test 2: bounce on channel 0, last 0->1 is edge 1
        bus.sw_in = 3'b001; step("t2_bounce", 3'b000, 3'b000, 3'b000, 1'b0);
        bus.sw_in = 3'b000; step("t2_bounce", 3'b000, 3'b000, 3'b000, 1'b0);
        bus.sw_in = 3'b001; step("t2_bounce", 3'b000, 3'b000, 3'b000, 1'b0);
        bus.sw_in = 3'b000; step("t2_bounce", 3'b000, 3'b000, 3'b000, 1'b0);
        bus.sw_in = 3'b001; step("t2_edge1", 3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 0; k < 4; k++) step("t2_wait", 3'b000, 3'b000, 3'b000, 1'b0);
        step("t2_rise", 3'b001, 3'b001, 3'b000, 1'b1);
        step("t2_after", 3'b001, 3'b000, 3'b000, 1'b0);
        bus.sw_in = 3'b000;
        for (int k = 0; k < 5; k++) step("t2_ret_wait", 3'b001, 3'b000, 3'b000, 1'b0);
        step("t2_ret_fall", 3'b000, 3'b000, 3'b001, 1'b1);
        step("t2_ret_after", 3'b000, 3'b000, 3'b000, 1'b0);

        // Test 3: channel 1 high for 3 cycles only (one short of qualifying)
        bus.sw_in = 3'b010;
        for (int k = 0; k < 3; k++) step("t3_glitch", 3'b000, 3'b000, 3'b000, 1'b0);
        bus.sw_in = 3'b000;
        for (int k = 0; k < 20; k++) step("t3_quiet", 3'b000, 3'b000, 3'b000, 1'b0);

        // Test 5: reset on edge 3 of a channel-2 qualification
        bus.sw_in = 3'b100;
        step("t5_e1", 3'b000, 3'b000, 3'b000, 1'b0);
        step("t5_e2", 3'b000, 3'b000, 3'b000, 1'b0);
        rst_n = 1'b0;
        step("t5_rst", 3'b000, 3'b000, 3'b000, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step("t5_wait", 3'b000, 3'b000, 3'b000, 1'b0);
        step("t5_rise", 3'b100, 3'b100, 3'b000, 1'b1);
        step("t5_after", 3'b100, 3'b000, 3'b000, 1'b0);

        // Test 6: simultaneous rise on ch0 and fall on ch2
        bus.sw_in = 3'b001;
        for (int k = 0; k < 5; k++) step("t6_wait", 3'b100, 3'b000, 3'b000, 1'b0);
        step("t6_flip", 3'b001, 3'b001, 3'b100, 1'b1);
        step("t6_after", 3'b001, 3'b000, 3'b000, 1'b0);
        step("t6_after2", 3'b001, 3'b000, 3'b000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
